eth_tx_framer: RTL and testbench
================================

// Module: eth_tx_framer
// PURPOSE
//   Upstream neighbour of phy_tx. Turns a byte stream (valid/ready, last-flagged) into a
//   complete 802.3 frame on an 8-bit SDR interface: preamble, SFD, payload, zero pad to
//   minimum length, CRC-32 FCS, then inter-frame gap. tx_en/tx_data feed phy_tx ctl/data.
// PARAMETERS
//   PREAMBLE_LEN  7   number of 0x55 bytes before SFD
//   MIN_FRAME     60  minimum bytes (DA..pad) before FCS; shorter payloads zero-padded
//   IFG_BYTES     12  idle cycles (tx_en=0) after last FCS byte, min 1
// PORTS
//   clk        in   1  byte clock (125 MHz, same clock as phy_tx)
//   rst        in   1  asynchronous, active-high reset
//   s_data     in   8  payload byte (DA first; no preamble/FCS)
//   s_valid    in   1  s_data valid
//   s_last     in   1  s_data is final payload byte of frame
//   s_ready    out  1  byte accepted when s_valid & s_ready
//   tx_en      out  1  frame byte valid -> phy_tx ctl
//   tx_data    out  8  frame byte -> phy_tx data
//   busy       out  1  high in any state but IDLE
//   frame_done out  1  one-cycle pulse with last FCS byte
//   underrun   out  1  one-cycle pulse when a frame is truncated
// BEHAVIOUR
//   - Reset (async): state IDLE; tx_en=0, tx_data=0x00, s_ready=0, busy=0, frame_done=0,
//     underrun=0; byte counter, CRC and IFG counter cleared. Reset mid-frame truncates it.
//   - tx_en, tx_data, frame_done, underrun are registered; s_ready is combinational
//     from state (high only in DATA), never depends on s_valid.
//   - States: IDLE -> PRE -> SFD -> DATA -> [PAD] -> FCS -> IFG -> IDLE.
//   - IDLE: s_valid=1 sampled at edge N -> tx_en=1, tx_data=0x55 from N+1. No byte consumed.
//   - PRE: PREAMBLE_LEN cycles of 0x55; SFD: one cycle of 0xD5.
//   - DATA: byte accepted at edge M appears on tx_data from M+1; no gaps between bytes.
//     s_last with accepted byte ends DATA: go PAD if byte count < MIN_FRAME, else FCS.
//   - Underrun: s_valid=0 in any DATA cycle -> next cycle tx_en=0, underrun pulses, go IFG
//     (frame truncated, no FCS). s_last with s_valid=0 is ignored.
//   - PAD: emit 0x00 until count (payload+pad) == MIN_FRAME.
//   - Byte counter 16 bits, saturates at 0xFFFF; no maximum length enforced.
//   - CRC-32: reflected poly 0xEDB88320, init 0xFFFFFFFF, over every DATA and PAD byte,
//     LSB-first per byte. FCS = ~crc, sent as 4 bytes, least significant byte first.
//   - FCS: 4 cycles; frame_done asserted with the 4th byte.
//   - IFG: tx_en=0, tx_data=0x00, s_ready=0 for exactly IFG_BYTES cycles, then IDLE.
//     A held s_valid restarts PRE the cycle after IDLE is reached (gap = IFG_BYTES+1
//     minimum between frames' tx_en).
//   - tx_en stays high with no gap from first 0x55 through last FCS byte.
// TESTING
//   1 14-byte payload (0x01..0x0E, s_last on 14th) -> tx_en high 72 cycles:
//     7x55, D5, 01..0E, 46x00, 4 FCS; frame_done on cycle 72; underrun=0.
//   2 100-byte payload -> tx_en high 112 cycles, no pad bytes, bytes in order.
//   3 FCS check: run CRC over DA..FCS of tests 1/2 at receiver -> residue 0xDEBB20E3;
//     payload "123456789" ASCII alone padded gives residue 0xDEBB20E3 too.
//   4 Underrun: drop s_valid after 20th byte -> tx_en low next cycle, underrun 1-cycle
//     pulse, no FCS, frame_done=0, then 12 idle cycles before IDLE.
//   5 Back-to-back: s_valid held with two 64-byte frames -> tx_en low exactly 13 cycles
//     between frames; second frame starts with 7x55, D5; both FCS correct.
//   6 Assert rst during payload byte 30 -> tx_en=0, s_ready=0, busy=0 immediately;
//     after release next s_valid starts clean preamble and a correct frame.

Source files
------------

// File: rtl/eth_tx_framer.sv
// eth_tx_framer: wraps a valid/ready byte stream into a complete Ethernet frame
// (preamble, SFD, payload, zero pad, CRC-32 FCS) and enforces the inter-frame gap.
// The state register names the byte the *next* clock edge will put on tx_data.
// This lets s_ready go high in the same cycle that the SFD is on the wire, so the
// first payload byte follows the SFD with no gap.
module eth_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_BYTES    = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam logic [7:0]  PRE_LAST  = 8'(PREAMBLE_LEN - 1);
  localparam logic [15:0] MIN_LEN   = 16'(MIN_FRAME);
  localparam logic [15:0] IFG_LAST  = 16'(IFG_BYTES);
  localparam logic [31:0] CRC_POLY  = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT  = 32'hFFFFFFFF;
  localparam logic [7:0]  BYTE_PRE  = 8'h55;
  localparam logic [7:0]  BYTE_SFD  = 8'hD5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_t;

  state_t      state_q;
  logic [7:0]  pre_cnt_q;
  logic [15:0] byte_cnt_q;
  logic [15:0] ifg_cnt_q;
  logic [1:0]  fcs_idx_q;
  logic [31:0] crc_q;
  logic        tx_en_q;
  logic [7:0]  tx_data_q;
  logic        frame_done_q;
  logic        underrun_q;

  logic [15:0] byte_cnt_d;
  logic [31:0] crc_data_d;
  logic [31:0] crc_pad_d;
  logic [31:0] fcs_w;

  // Reflected CRC-32 update for one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] b);
    logic [31:0] c;
    c = crc_in ^ {24'h000000, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Next values for the counter and the CRC, shared by the DATA and PAD branches.
  always_comb begin
    byte_cnt_d = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : (byte_cnt_q + 16'd1);
    crc_data_d = crc_byte(crc_q, s_data);
    crc_pad_d  = crc_byte(crc_q, 8'h00);
  end

  assign fcs_w      = ~crc_q;
  assign s_ready    = (state_q == ST_DATA);
  assign busy       = (state_q != ST_IDLE);
  assign tx_en      = tx_en_q;
  assign tx_data    = tx_data_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

  // Framing FSM with registered wire outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pre_cnt_q    <= 8'd0;
      byte_cnt_q   <= 16'd0;
      ifg_cnt_q    <= 16'd0;
      fcs_idx_q    <= 2'd0;
      crc_q        <= CRC_INIT;
      tx_en_q      <= 1'b0;
      tx_data_q    <= 8'h00;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_en_q   <= 1'b0;
          tx_data_q <= 8'h00;
          if (s_valid) begin
            // First preamble byte goes out now; nothing is consumed yet.
            tx_en_q   <= 1'b1;
            tx_data_q <= BYTE_PRE;
            pre_cnt_q <= 8'd1;
            state_q   <= (PREAMBLE_LEN > 1) ? ST_PRE : ST_SFD;
          end
        end
        ST_PRE: begin
          tx_en_q   <= 1'b1;
          tx_data_q <= BYTE_PRE;
          pre_cnt_q <= pre_cnt_q + 8'd1;
          if (pre_cnt_q == PRE_LAST) begin
            state_q <= ST_SFD;
          end
        end
        ST_SFD: begin
          tx_en_q    <= 1'b1;
          tx_data_q  <= BYTE_SFD;
          byte_cnt_q <= 16'd0;
          crc_q      <= CRC_INIT;
          state_q    <= ST_DATA;
        end
        ST_DATA: begin
          if (s_valid) begin
            tx_en_q    <= 1'b1;
            tx_data_q  <= s_data;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_data_d;
            if (s_last) begin
              fcs_idx_q <= 2'd0;
              state_q   <= (byte_cnt_d < MIN_LEN) ? ST_PAD : ST_FCS;
            end
          end else begin
            // Source starved mid-frame: truncate with no FCS. The first IFG cycle
            // is already idle on the wire, so the gap counter starts one step ahead.
            tx_en_q    <= 1'b0;
            tx_data_q  <= 8'h00;
            underrun_q <= 1'b1;
            ifg_cnt_q  <= 16'd1;
            state_q    <= ST_IFG;
          end
        end
        ST_PAD: begin
          tx_en_q    <= 1'b1;
          tx_data_q  <= 8'h00;
          byte_cnt_q <= byte_cnt_d;
          crc_q      <= crc_pad_d;
          if (byte_cnt_d >= MIN_LEN) begin
            fcs_idx_q <= 2'd0;
            state_q   <= ST_FCS;
          end
        end
        ST_FCS: begin
          tx_en_q   <= 1'b1;
          tx_data_q <= fcs_w[{fcs_idx_q, 3'b000} +: 8];
          fcs_idx_q <= fcs_idx_q + 2'd1;
          if (fcs_idx_q == 2'd3) begin
            frame_done_q <= 1'b1;
            // The first IFG cycle still shows the last FCS byte, hence counting from 0.
            ifg_cnt_q    <= 16'd0;
            state_q      <= ST_IFG;
          end
        end
        ST_IFG: begin
          tx_en_q   <= 1'b0;
          tx_data_q <= 8'h00;
          if (ifg_cnt_q >= IFG_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            ifg_cnt_q <= ifg_cnt_q + 16'd1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          tx_en_q   <= 1'b0;
          tx_data_q <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: builds expected frames byte by byte and checks
// the wire stream, frame lengths, inter-frame gaps, pulses and the FCS residue.
module tb_eth_tx_framer;

  logic       clk;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  eth_tx_framer dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] src_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  int         exp_len_q[$];
  int         flen_q[$];

  logic prev_en;
  int   en_run, low_run, last_gap;
  int   fd_cnt, fd_len, ur_cnt, ur_low, ur_busy;
  logic ur_track;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  function automatic logic [7:0] pat(input int kind, input int i);
    string s;
    s = "123456789";
    case (kind)
      0:       return 8'(i + 1);
      1:       return s[i];
      2:       return 8'(i * 7 + 3);
      default: return 8'(i * 13 + 8'h80);
    endcase
  endfunction

  // Queue one frame on the source and append its expected wire image.
  // trunc > 0 sends only that many bytes, without s_last (underrun case).
  task automatic build_frame(input int len, input int kind, input int trunc);
    logic [31:0] crc;
    int n, total;
    crc = 32'hFFFFFFFF;
    n = (trunc > 0) ? trunc : len;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < n; i++) begin
      src_q.push_back({(trunc == 0 && i == len - 1), pat(kind, i)});
      exp_q.push_back(pat(kind, i));
      crc = crc_upd(crc, pat(kind, i));
    end
    if (trunc > 0) begin
      exp_len_q.push_back(8 + n);
    end else begin
      total = len;
      while (total < 60) begin
        exp_q.push_back(8'h00);
        crc = crc_upd(crc, 8'h00);
        total++;
      end
      crc = ~crc;
      for (int k = 0; k < 4; k++) exp_q.push_back(crc[8*k +: 8]);
      exp_len_q.push_back(8 + total + 4);
    end
  endtask

  task automatic clear_mon();
    exp_q.delete(); cap_q.delete(); exp_len_q.delete(); flen_q.delete();
    prev_en = 1'b0; en_run = 0; low_run = 0; last_gap = -1;
    fd_cnt = 0; fd_len = 0; ur_cnt = 0; ur_low = 0; ur_busy = 0; ur_track = 1'b0;
  endtask

  // One clock: sample outputs at the falling edge, then drive the next input beat.
  task automatic tick();
    @(negedge clk);
    if (tx_en) begin
      if (!prev_en) begin
        last_gap = low_run;
        en_run = 0;
      end
      en_run++;
      cap_q.push_back(tx_data);
      low_run = 0;
    end else begin
      if (prev_en) flen_q.push_back(en_run);
      low_run++;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_len = en_run;
    end
    if (underrun) begin
      ur_cnt++;
      ur_low = low_run;
      ur_track = 1'b1;
      ur_busy = 0;
    end
    if (ur_track) begin
      if (busy) ur_busy++;
      else ur_track = 1'b0;
    end
    prev_en = tx_en;
    if (src_q.size() > 0) begin
      s_valid = 1'b1;
      s_data  = src_q[0][7:0];
      s_last  = src_q[0][8];
      if (s_ready) void'(src_q.pop_front());
    end else begin
      s_valid = 1'b0;
      s_data  = 8'h00;
      s_last  = 1'b0;
    end
  endtask

  task automatic run_until_idle(input string tag);
    int idle;
    int budget;
    idle = 0;
    budget = 3000;
    while (idle < 3 && budget > 0) begin
      tick();
      budget--;
      if (src_q.size() == 0 && !busy && !tx_en) idle++;
      else idle = 0;
    end
    if (budget == 0) check({tag, " timeout"}, 32'd1, 32'd0);
  endtask

  task automatic check_frames(input string tag, input logic full);
    int start;
    logic [31:0] r;
    check({tag, " nframes"}, flen_q.size(), exp_len_q.size());
    for (int f = 0; f < exp_len_q.size() && f < flen_q.size(); f++)
      check({tag, " len"}, flen_q[f], exp_len_q[f]);
    check({tag, " nbytes"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check({tag, " byte"}, {24'h0, cap_q[i]}, {24'h0, exp_q[i]});
    if (full) begin
      start = 0;
      for (int f = 0; f < exp_len_q.size(); f++) begin
        r = 32'hFFFFFFFF;
        for (int i = start + 8; i < start + exp_len_q[f] && i < cap_q.size(); i++)
          r = crc_upd(r, cap_q[i]);
        check({tag, " residue"}, r, 32'hDEBB20E3);
        start += exp_len_q[f];
      end
    end
  endtask

  initial begin
    int budget;
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    check("rst tx_en", tx_en, 0);
    check("rst tx_data", tx_data, 0);
    check("rst s_ready", s_ready, 0);
    check("rst busy", busy, 0);
    check("rst frame_done", frame_done, 0);
    check("rst underrun", underrun, 0);
    rst = 1'b0;
    repeat (2) tick();

    // 1: 14-byte payload padded to 60
    clear_mon();
    build_frame(14, 0, 0);
    run_until_idle("t1");
    check_frames("t1", 1'b1);
    check("t1 frame_done cnt", fd_cnt, 1);
    check("t1 frame_done pos", fd_len, 72);
    check("t1 underrun", ur_cnt, 0);
    $display("[TB] t1 14-byte frame: len %0d", (flen_q.size() > 0) ? flen_q[0] : -1);

    // 2: 100-byte payload, no pad
    clear_mon();
    build_frame(100, 2, 0);
    run_until_idle("t2");
    check_frames("t2", 1'b1);
    check("t2 frame_done cnt", fd_cnt, 1);
    check("t2 frame_done pos", fd_len, 112);
    $display("[TB] t2 100-byte frame: len %0d", (flen_q.size() > 0) ? flen_q[0] : -1);

    // 3: ASCII "123456789" padded
    clear_mon();
    build_frame(9, 1, 0);
    run_until_idle("t3");
    check_frames("t3", 1'b1);
    check("t3 frame_done cnt", fd_cnt, 1);
    $display("[TB] t3 ascii frame: len %0d", (flen_q.size() > 0) ? flen_q[0] : -1);

    // 4: underrun after 20 bytes
    clear_mon();
    build_frame(64, 3, 20);
    run_until_idle("t4");
    check_frames("t4", 1'b0);
    check("t4 underrun cnt", ur_cnt, 1);
    check("t4 underrun pos", ur_low, 1);
    check("t4 ifg busy", ur_busy, 12);
    check("t4 frame_done", fd_cnt, 0);
    $display("[TB] t4 underrun: len %0d pulses %0d", (flen_q.size() > 0) ? flen_q[0] : -1, ur_cnt);

    // 5: back-to-back 64-byte frames with s_valid held
    clear_mon();
    build_frame(64, 0, 0);
    build_frame(64, 2, 0);
    run_until_idle("t5");
    check_frames("t5", 1'b1);
    check("t5 gap", last_gap, 13);
    check("t5 frame_done cnt", fd_cnt, 2);
    $display("[TB] t5 back-to-back: gap %0d", last_gap);

    // 6: reset during payload byte 30, then a clean frame
    clear_mon();
    build_frame(64, 3, 0);
    budget = 500;
    while (src_q.size() > 34 && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check("t6 timeout", 32'd1, 32'd0);
    rst = 1'b1;
    #1;
    check("t6 rst tx_en", tx_en, 0);
    check("t6 rst s_ready", s_ready, 0);
    check("t6 rst busy", busy, 0);
    check("t6 rst tx_data", tx_data, 0);
    s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    src_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_mon();
    build_frame(20, 2, 0);
    run_until_idle("t6");
    check_frames("t6", 1'b1);
    check("t6 frame_done cnt", fd_cnt, 1);
    $display("[TB] t6 after reset: len %0d", (flen_q.size() > 0) ? flen_q[0] : -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
